// File: rtl/gf_accum_pkg.sv
// -----------------------------------------------------------------------------
// gf_accum_pkg
// Shared types and constants for the GF/integer stream accumulator family.
//   state_e      : accumulator FSM states (IDLE, ACCUM, HOLD)
//   GF_MODE_XOR  : mode value selecting GF(2^n) addition (bitwise XOR)
//   GF_MODE_INT  : mode value selecting integer addition mod 2^WIDTH
// -----------------------------------------------------------------------------
package gf_accum_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_e;

  localparam logic GF_MODE_XOR = 1'b1;
  localparam logic GF_MODE_INT = 1'b0;

endpackage : gf_accum_pkg

// File: rtl/gf_add_unit.sv
// -----------------------------------------------------------------------------
// gf_add_unit
// Combinational two-operand adder for GF(2^n) (XOR) or integer arithmetic.
// Integer addition is done WIDTH+1 bits wide; bit WIDTH is the carry.
//
// Configuration macro: GF_ACCUM_SAT_EN
//   defined   : integer carry-out clamps sum to all ones (saturating)
//   undefined : integer sum wraps mod 2^WIDTH
//   GF mode is unaffected by the macro; carry is always 0 in GF mode.
//
// Ports:
//   a, b   in  WIDTH  operands
//   mode   in  1      GF_MODE_XOR or GF_MODE_INT
//   sum    out WIDTH  result
//   carry  out 1      integer-mode carry-out
// -----------------------------------------------------------------------------
module gf_add_unit
  import gf_accum_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mode,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);

  logic [WIDTH:0] wide_sum;

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the block leaves a value unassigned (which would infer a latch).
  always_comb begin
    wide_sum = {1'b0, a} + {1'b0, b};
    sum      = a ^ b;
    carry    = 1'b0;
    if (mode == GF_MODE_INT) begin
      carry = wide_sum[WIDTH];
`ifdef GF_ACCUM_SAT_EN
      // Once the accumulator is all ones, any further nonzero operand carries
      // again, so saturation is sticky without extra state.
      sum = wide_sum[WIDTH] ? {WIDTH{1'b1}} : wide_sum[WIDTH-1:0];
`else
      sum = wide_sum[WIDTH-1:0];
`endif
    end
  end

endmodule : gf_add_unit

// File: rtl/gf_stream_accum.sv
// -----------------------------------------------------------------------------
// gf_stream_accum
// Streaming multi-operand accumulator. Reduces a frame of WIDTH-bit operands,
// received over valid/ready, with GF(2^n) addition (XOR) or integer addition
// mod 2^WIDTH. The mode is latched on the first beat of each frame. The frame
// result is held on out_* until out_ready is seen.
//
// Configuration macro: GF_ACCUM_SAT_EN (saturating integer mode, see gf_add_unit)
//
// Parameters:
//   WIDTH    operand/result width (>= 2)
//   MAX_LEN  maximum beats per frame; reaching it ends the frame (>= 2)
//   CNT_W    beat-count width, derived from MAX_LEN
//
// Ports:
//   clk        in   1      clock, rising edge
//   rst        in   1      synchronous active-high reset
//   gf_option  in   1      1 = GF add, 0 = integer add; sampled on first beat
//   in_valid   in   1      operand valid
//   in_ready   out  1      block can accept an operand
//   in_data    in   WIDTH  operand
//   in_last    in   1      final operand of frame
//   out_valid  out  1      result valid (held until out_ready)
//   out_ready  in   1      consumer accepts result
//   out_sum    out  WIDTH  frame result
//   out_count  out  CNT_W  operands accumulated in frame
//   out_ovf    out  1      integer carry-out occurred in frame
//   out_trunc  out  1      frame ended by MAX_LEN rather than in_last
// -----------------------------------------------------------------------------
module gf_stream_accum
  import gf_accum_pkg::*;
#(
  parameter  int WIDTH   = 32,
  parameter  int MAX_LEN = 16,
  localparam int CNT_W   = $clog2(MAX_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             gf_option,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf,
  output logic             out_trunc
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_LEN);

  state_e           state;
  logic [WIDTH-1:0] acc;
  logic             mode;
  logic [CNT_W-1:0] count;
  logic             ovf;
  logic             trunc;

  logic             beat;
  logic [CNT_W-1:0] count_inc;
  logic [WIDTH-1:0] add_sum;
  logic             add_carry;

  // Ready is suppressed while reset is asserted so no beat appears accepted
  // in a cycle whose state update is discarded.
  assign in_ready  = !rst && (state != HOLD);
  assign beat      = in_valid && in_ready;
  assign count_inc = count + 1'b1;

  gf_add_unit #(
    .WIDTH (WIDTH)
  ) u_add (
    .a     (acc),
    .b     (in_data),
    .mode  (mode),
    .sum   (add_sum),
    .carry (add_carry)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  // NOTE: the datapath registers are reset as well as the FSM because the
  // outputs have defined reset values, not just a defined state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      acc   <= '0;
      mode  <= GF_MODE_INT;
      count <= '0;
      ovf   <= 1'b0;
      trunc <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (beat) begin
            acc   <= in_data;
            mode  <= gf_option;
            count <= CNT_W'(1);
            ovf   <= 1'b0;
            trunc <= 1'b0;
            state <= in_last ? HOLD : ACCUM;
          end
        end
        ACCUM: begin
          if (beat) begin
            acc   <= add_sum;
            count <= count_inc;
            ovf   <= ovf | add_carry;
            // in_last wins over the length limit, so a frame that ends
            // exactly at MAX_LEN is not reported as truncated.
            if (in_last) begin
              state <= HOLD;
            end else if (count_inc == MAX_CNT) begin
              state <= HOLD;
              trunc <= 1'b1;
            end
          end
        end
        HOLD: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign out_valid = (state == HOLD);
  assign out_sum   = acc;
  assign out_count = count;
  assign out_ovf   = ovf;
  assign out_trunc = trunc;

endmodule : gf_stream_accum

// File: tb/tb_gf_stream_accum.sv
// -----------------------------------------------------------------------------
// tb_gf_stream_accum
// Directed bench for gf_stream_accum with WIDTH=32, MAX_LEN=4. Expected values
// are hand-derived constants. Build with GF_ACCUM_SAT_EN defined to check the
// saturating integer variant.
// -----------------------------------------------------------------------------
module tb_gf_stream_accum;

  localparam int WIDTH   = 32;
  localparam int MAX_LEN = 4;
  localparam int CNT_W   = $clog2(MAX_LEN + 1);

  logic             clk = 1'b0;
  logic             rst;
  logic             gf_option;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic [CNT_W-1:0] out_count;
  logic             out_ovf;
  logic             out_trunc;

  int n_vec = 0;
  int n_bad = 0;

  logic [WIDTH-1:0] held_sum;

  gf_stream_accum #(
    .WIDTH   (WIDTH),
    .MAX_LEN (MAX_LEN)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .gf_option (gf_option),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_count (out_count),
    .out_ovf   (out_ovf),
    .out_trunc (out_trunc)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one beat for one edge; in_ready must be high so it is accepted.
  task automatic send(input logic [WIDTH-1:0] data, input logic last,
                      input logic gf);
    in_valid  = 1'b1;
    in_data   = data;
    in_last   = last;
    gf_option = gf;
    check("beat_ready", in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic check_result(input string tag, input logic [WIDTH-1:0] sum,
                              input logic [CNT_W-1:0] cnt, input logic ovf,
                              input logic trunc);
    check({tag, "_valid"}, out_valid, 1'b1);
    check({tag, "_sum"},   out_sum,   sum);
    check({tag, "_count"}, out_count, cnt);
    check({tag, "_ovf"},   out_ovf,   ovf);
    check({tag, "_trunc"}, out_trunc, trunc);
  endtask

  task automatic consume();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("consume_valid", out_valid, 1'b0);
    check("consume_ready", in_ready,  1'b1);
  endtask

  initial begin
    rst       = 1'b1;
    gf_option = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;

    // Reset state
    tick();
    tick();
    check("rst_in_ready",  in_ready,  1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_sum",       out_sum,   32'd0);
    check("rst_count",     out_count, 3'd0);
    check("rst_ovf",       out_ovf,   1'b0);
    check("rst_trunc",     out_trunc, 1'b0);
    rst = 1'b0;
    #1;
    check("idle_ready", in_ready, 1'b1);

    // GF frame [10, 25] with out_ready high: 10 ^ 25 = 19
    out_ready = 1'b1;
    send(32'd10, 1'b0, 1'b1);
    check("gf2_mid_valid", out_valid, 1'b0);
    send(32'd25, 1'b1, 1'b1);
    check_result("gf2", 32'd19, 3'd2, 1'b0, 1'b0);
    tick();
    out_ready = 1'b0;
    check("gf2_done_valid", out_valid, 1'b0);

    // Integer frame [10, 25, 28, 72] = 135; in_last lands on MAX_LEN -> no trunc
    send(32'd10, 1'b0, 1'b0);
    send(32'd25, 1'b0, 1'b0);
    send(32'd28, 1'b0, 1'b0);
    send(32'd72, 1'b1, 1'b0);
    check_result("int4", 32'd135, 3'd4, 1'b0, 1'b0);
    consume();

    // Same frame in GF mode: 10^25^28^72 = 71. gf_option toggled after the
    // first beat and an idle cycle mid-frame must not change anything.
    send(32'd10, 1'b0, 1'b1);
    send(32'd25, 1'b0, 1'b0);
    tick();
    check("gf4_idle_valid", out_valid, 1'b0);
    send(32'd28, 1'b0, 1'b0);
    send(32'd72, 1'b1, 1'b0);
    check_result("gf4", 32'd71, 3'd4, 1'b0, 1'b0);

    // Backpressure: 3 cycles with out_ready low and a beat offered in HOLD
    held_sum = out_sum;
    in_valid = 1'b1;
    in_data  = 32'd99;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_in_ready",  in_ready,  1'b0);
      check("bp_out_valid", out_valid, 1'b1);
      check("bp_sum",       out_sum,   held_sum);
      check("bp_count",     out_count, 3'd4);
    end
    in_valid = 1'b0;
    consume();

    // Integer carry-out: 0xFFFFFFFF + 2
    send(32'hFFFF_FFFF, 1'b0, 1'b0);
    send(32'd2,         1'b1, 1'b0);
`ifdef GF_ACCUM_SAT_EN
    check_result("int_ovf", 32'hFFFF_FFFF, 3'd2, 1'b1, 1'b0);
`else
    check_result("int_ovf", 32'd1, 3'd2, 1'b1, 1'b0);
`endif
    consume();

    // Truncation: beats of 1 with in_last low; frame ends at MAX_LEN=4
    for (int i = 0; i < 4; i++) send(32'd1, 1'b0, 1'b0);
    check_result("trunc", 32'd4, 3'd4, 1'b0, 1'b1);
    // Fifth beat offered in HOLD must wait for the handshake
    in_valid = 1'b1;
    in_data  = 32'd1;
    in_last  = 1'b1;
    tick();
    check("trunc_hold_ready", in_ready, 1'b0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("trunc_gap_valid", out_valid, 1'b0);
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
    check_result("fifth", 32'd1, 3'd1, 1'b0, 1'b0);
    consume();

    // Reset mid-frame after 2 of 4 beats, with a beat offered during reset
    send(32'd7, 1'b0, 1'b0);
    send(32'd9, 1'b0, 1'b0);
    rst      = 1'b1;
    in_valid = 1'b1;
    in_data  = 32'd100;
    tick();
    check("mrst_in_ready",  in_ready,  1'b0);
    check("mrst_out_valid", out_valid, 1'b0);
    check("mrst_sum",       out_sum,   32'd0);
    check("mrst_count",     out_count, 3'd0);
    check("mrst_ovf",       out_ovf,   1'b0);
    check("mrst_trunc",     out_trunc, 1'b0);
    rst      = 1'b0;
    in_valid = 1'b0;
    #1;
    check("mrst_idle_ready", in_ready, 1'b1);

    // Fresh GF frame [5, 3] = 6
    send(32'd5, 1'b0, 1'b1);
    send(32'd3, 1'b1, 1'b1);
    check_result("post_rst", 32'd6, 3'd2, 1'b0, 1'b0);
    consume();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule : tb_gf_stream_accum
